// File: rtl/div_4bit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_4bit_seq_pkg
// Brief    : State encoding and default width for the sequential divider.
// Revision : 1.0
// ============================================================================
package div_4bit_seq_pkg;

  localparam int c_default_width = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_4bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : div_4bit_seq_if
// Brief    : Start/busy/done handshake and operand/result bus of the divider.
// Revision : 1.0
// ============================================================================
interface div_4bit_seq_if
  import div_4bit_seq_pkg::*;
#(
  parameter int WIDTH = c_default_width
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/div_4bit_seq_sub_nbit.sv
`default_nettype none
// ============================================================================
// Module   : sub_nbit
// Brief    : N-bit ripple-borrow subtractor (diff = a - b) of full-subtractor cells.
// Revision : 1.0
// ============================================================================
module sub_nbit
  import div_4bit_seq_pkg::*;
#(
  parameter int N = c_default_width + 1
) (
  input  wire [N-1:0] a,
  input  wire [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end

  assign bout = w_borrow[N];

endmodule
`default_nettype wire

// File: rtl/div_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_4bit_seq
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module div_4bit_seq
  import div_4bit_seq_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  wire           clk,
  input  wire           rst_n,
  div_4bit_seq_if.slave bus
);

  localparam int              c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rmdr;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_bout;
  logic             w_restore;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept;
  logic             w_last;

  // The restored remainder is always below the divisor, so WIDTH bits of
  // state suffice; the extra bit only exists inside the trial subtraction.
  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_restore  = w_bout | w_diff[WIDTH];
  assign w_rem_next = w_restore ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_restore};
  assign w_accept   = bus.start && (r_state != CALC);
  assign w_last     = (r_cnt == c_last);

  sub_nbit #(
    .N (WIDTH + 1)
  ) u_sub (
    .a    (w_shift),
    .b    ({1'b0, r_d}),
    .diff (w_diff),
    .bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (w_last)    w_next = DONE;
      DONE: begin
        if (bus.start) w_next = (bus.divisor == '0) ? DONE : CALC;
        else           w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Results are loaded only on completion so they hold through IDLE and CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_quot <= '0;
      r_rmdr <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_q   <= bus.dividend;
      r_d   <= bus.divisor;
      r_dbz <= (bus.divisor == '0);
      if (bus.divisor == '0) begin
        r_quot <= '1;
        r_rmdr <= bus.dividend;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= w_q_next;
        r_rmdr <= w_rem_next;
      end
    end
  end

  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rmdr;
  assign bus.div_by_zero = r_dbz;
  assign bus.busy        = (r_state == CALC);
  assign bus.done        = (r_state == DONE);

endmodule
`default_nettype wire
